// File: rtl/ub_pkg.sv
// rtl/ub_pkg.sv - shared types for the unified_buffer port arbiter
package ub_pkg;

  typedef enum logic [1:0] {
    UB_MODE_FIFO,
    UB_MODE_COMPUTE,
    UB_MODE_STORE,
    UB_MODE_RSVD
  } ub_mode_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_ACTIVE,
    ARB_RELEASE
  } arb_state_e;

  // Transfer-select decode, packed as {compute_en, fifo_en, store_en}.
  function automatic logic [2:0] mode_enables(input ub_mode_e mode);
    case (mode)
      UB_MODE_FIFO:    mode_enables = 3'b010;
      UB_MODE_COMPUTE: mode_enables = 3'b100;
      UB_MODE_STORE:   mode_enables = 3'b001;
      default:         mode_enables = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/ub_port_arbiter_rr_picker.sv
// rtl/ub_port_arbiter_rr_picker.sv - combinational round-robin winner select
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [PW-1:0]      winner_idx,
  output logic               valid
);

  int idx;

  // Scan rr_ptr, rr_ptr+1, ... with wraparound; first set bit wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    idx        = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (!valid && req[idx]) begin
        valid       = 1'b1;
        winner[idx] = 1'b1;
        winner_idx  = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/ub_port_arbiter.sv
// rtl/ub_port_arbiter.sv - round-robin owner of the unified_buffer control port
module ub_port_arbiter
  import ub_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDRESS_SIZE   = 9,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_we,
  input  logic [NUM_REQ*2-1:0]         req_mode,
  input  logic [NUM_REQ-1:0]           req_section,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           req_done,
  output logic [NUM_REQ-1:0]           req_err,
  output logic                         buf_we,
  output logic                         buf_re,
  output logic                         buf_compute_en,
  output logic                         buf_fifo_en,
  output logic                         buf_store_en,
  output logic                         buf_section,
  output logic [ADDRESS_SIZE-1:0]      buf_address,
  input  logic                         buf_done,
  output logic                         busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]     owner_q, owner_d;
  logic [PW-1:0]          owner_idx_q, owner_idx_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   we_q, we_d;
  ub_mode_e               mode_q, mode_d;
  logic                   sec_q, sec_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                   err_q, err_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0]     pick_winner;
  logic [PW-1:0]          pick_idx;
  logic                   pick_valid;
  logic [2:0]             en_d;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_picker (
    .req        (req),
    .rr_ptr     (rr_ptr_q),
    .winner     (pick_winner),
    .winner_idx (pick_idx),
    .valid      (pick_valid)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    owner_idx_d = owner_idx_q;
    rr_ptr_d    = rr_ptr_q;
    we_d        = we_q;
    mode_d      = mode_q;
    sec_d       = sec_q;
    addr_d      = addr_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d     = ARB_GRANT;
          owner_d     = pick_winner;
          owner_idx_d = pick_idx;
          we_d        = req_we[pick_idx];
          mode_d      = ub_mode_e'(req_mode[int'(pick_idx)*2 +: 2]);
          sec_d       = req_section[pick_idx];
          addr_d      = req_addr[int'(pick_idx)*ADDRESS_SIZE +: ADDRESS_SIZE];
          err_d       = 1'b0;
          cnt_d       = '0;
        end
      end
      ARB_GRANT: begin
        if (mode_q == UB_MODE_RSVD) begin
          state_d = ARB_RELEASE;
          err_d   = 1'b1;
        end else begin
          state_d = ARB_ACTIVE;
          cnt_d   = '0;
        end
      end
      ARB_ACTIVE: begin
        // buf_done is checked first so a coincident timeout reports success.
        if (buf_done) begin
          state_d = ARB_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          state_d = ARB_RELEASE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        state_d  = ARB_IDLE;
        cnt_d    = '0;
        rr_ptr_d = (int'(owner_idx_q) == NUM_REQ - 1) ? '0 : owner_idx_q + 1'b1;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign en_d = (state_d == ARB_ACTIVE) ? mode_enables(mode_d) : 3'b000;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= '0;
      owner_idx_q <= '0;
      rr_ptr_q    <= '0;
      we_q        <= 1'b0;
      mode_q      <= UB_MODE_FIFO;
      sec_q       <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_idx_q <= owner_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      mode_q      <= mode_d;
      sec_q       <= sec_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs are registered from the next-state view so they align with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant          <= '0;
      req_done       <= '0;
      req_err        <= '0;
      buf_we         <= 1'b0;
      buf_re         <= 1'b0;
      buf_compute_en <= 1'b0;
      buf_fifo_en    <= 1'b0;
      buf_store_en   <= 1'b0;
      buf_section    <= 1'b0;
      buf_address    <= '0;
      busy           <= 1'b0;
    end else begin
      grant          <= (state_d != ARB_IDLE) ? owner_d : '0;
      req_done       <= (state_d == ARB_RELEASE) ? owner_d : '0;
      req_err        <= (state_d == ARB_RELEASE && err_d) ? owner_d : '0;
      buf_we         <= (state_d == ARB_ACTIVE) && we_d;
      buf_re         <= (state_d == ARB_ACTIVE) && !we_d;
      buf_compute_en <= en_d[2];
      buf_fifo_en    <= en_d[1];
      buf_store_en   <= en_d[0];
      buf_section    <= sec_d;
      buf_address    <= addr_d;
      busy           <= (state_d != ARB_IDLE);
    end
  end

endmodule

// File: tb/tb_ub_port_arbiter.sv
// tb/tb_ub_port_arbiter.sv - randomized transaction-level check of ub_port_arbiter
module tb_ub_port_arbiter;

  localparam int N   = 4;
  localparam int AW  = 9;
  localparam int TO  = 255;
  localparam int AWT = N * AW;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req, req_we, req_section;
  logic [2*N-1:0] req_mode;
  logic [AWT-1:0] req_addr;
  logic [N-1:0]   grant, req_done, req_err;
  logic           buf_we, buf_re, buf_compute_en, buf_fifo_en, buf_store_en;
  logic           buf_section, buf_done, busy;
  logic [AW-1:0]  buf_address;

  int vectors = 0;
  int miscompares = 0;
  int rr = 0;

  ub_port_arbiter #(
    .NUM_REQ        (N),
    .ADDRESS_SIZE   (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req            (req),
    .req_we         (req_we),
    .req_mode       (req_mode),
    .req_section    (req_section),
    .req_addr       (req_addr),
    .grant          (grant),
    .req_done       (req_done),
    .req_err        (req_err),
    .buf_we         (buf_we),
    .buf_re         (buf_re),
    .buf_compute_en (buf_compute_en),
    .buf_fifo_en    (buf_fifo_en),
    .buf_store_en   (buf_store_en),
    .buf_section    (buf_section),
    .buf_address    (buf_address),
    .buf_done       (buf_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++)
      if (r[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic check_strobes(input string tag, input bit on, input logic we, input logic [1:0] mode);
    check({tag, ".we"},      buf_we,         on && we);
    check({tag, ".re"},      buf_re,         on && !we);
    check({tag, ".fifo"},    buf_fifo_en,    on && mode == 2'd0);
    check({tag, ".compute"}, buf_compute_en, on && mode == 2'd1);
    check({tag, ".store"},   buf_store_en,   on && mode == 2'd2);
  endtask

  task automatic scramble();
    req_we      = N'($urandom);
    req_section = N'($urandom);
    req_mode    = (2*N)'($urandom);
    req_addr    = AWT'({$urandom, $urandom});
  endtask

  // One transaction from IDLE back to IDLE; delay<0 means buf_done never comes.
  task automatic run_txn(input logic [N-1:0] reqv, input bit hold, input int delay, input bit done_in_grant);
    int w, k;
    logic we, sec, err;
    logic [1:0] mode;
    logic [AW-1:0] addr;
    req = reqv;
    w = pick(reqv);
    if (w < 0) begin
      tick();
      check("idle.busy", busy, 0);
      check("idle.grant", grant, 0);
      return;
    end
    we   = req_we[w];
    mode = req_mode[2*w +: 2];
    sec  = req_section[w];
    addr = req_addr[AW*w +: AW];
    err  = 1'b0;
    tick();
    check("grant", grant, 64'(1) << w);
    check("grant.busy", busy, 1);
    check("grant.done", req_done, 0);
    check_strobes("grant", 0, we, mode);
    if (!hold) req = '0;
    scramble();
    buf_done = done_in_grant;
    if (mode == 2'd3) begin
      tick();
      buf_done = 1'b0;
      err = 1'b1;
    end else begin
      tick();
      buf_done = 1'b0;
      k = 1;
      forever begin
        check_strobes("active", 1, we, mode);
        check("active.addr", buf_address, addr);
        check("active.sec", buf_section, sec);
        check("active.grant", grant, 64'(1) << w);
        if (k == delay) begin
          buf_done = 1'b1;
          tick();
          buf_done = 1'b0;
          break;
        end
        if (k == TO) begin
          err = 1'b1;
          tick();
          break;
        end
        k++;
        tick();
      end
    end
    check("release.done", req_done, 64'(1) << w);
    check("release.err", req_err, err ? (64'(1) << w) : 64'(0));
    check("release.grant", grant, 64'(1) << w);
    check_strobes("release", 0, we, mode);
    rr = (w + 1) % N;
    tick();
    check("after.busy", busy, 0);
    check("after.grant", grant, 0);
    check("after.done", req_done, 0);
    check("after.err", req_err, 0);
    check_strobes("after", 0, we, mode);
  endtask

  initial begin
    rst = 1'b1;
    req = '0; req_we = '0; req_mode = '0; req_section = '0; req_addr = '0;
    buf_done = 1'b0;
    tick();
    tick();
    check("rst.grant", grant, 0);
    check("rst.busy", busy, 0);
    check("rst.addr", buf_address, 0);
    check("rst.done", {req_done, req_err}, 0);
    check_strobes("rst", 0, 1'b0, 2'd0);
    rst = 1'b0;
    tick();

    req_addr[AW-1:0] = 9'h012;
    run_txn(4'b0001, 0, 4, 0);

    for (int i = 0; i < 5; i++) begin
      scramble();
      run_txn(4'b1111, 1, 3, 0);
    end

    scramble();
    req_mode[5:4] = 2'd2;
    req_we[2] = 1'b1;
    run_txn(4'b0100, 0, -1, 1);
    check("rr.after.timeout", pick(4'b1111), 3);
    run_txn(4'b1111, 0, 2, 0);

    req_mode[3:2] = 2'd3;
    run_txn(4'b0010, 0, 2, 0);

    req_mode[1:0] = 2'd1;
    run_txn(4'b0001, 0, TO, 0);

    req_mode[7:6] = 2'd0;
    req_we[3] = 1'b1;
    req = 4'b1000;
    tick();
    req = '0;
    tick();
    check("pre_rst.we", buf_we, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rr = 0;
    check("mid_rst.grant", grant, 0);
    check("mid_rst.busy", busy, 0);
    check("mid_rst.pulses", {req_done, req_err}, 0);
    check_strobes("mid_rst", 0, 1'b1, 2'd0);
    run_txn(4'b0101, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      int d;
      scramble();
      d = ($urandom_range(0, 19) == 0) ? -1 : int'($urandom_range(1, 6));
      run_txn(N'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), d, bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
